// File: rtl/mic_sample_arbiter.sv
// Round-robin merge of NUM_CH per-mic sample strobes into one valid/ready stream tagged with channel ID.
// Define MIC_ARB_TIMESTAMP_EN to add tick_in/ts_out and per-sample capture timestamps.
module mic_sample_arbiter #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 16
`ifdef MIC_ARB_TIMESTAMP_EN
    ,
    parameter int TS_W   = 16
`endif
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_CH-1:0]          valid_in,
    input  logic [NUM_CH*DATA_W-1:0]   data_in,
    input  logic                       ready_in,
    output logic                       valid_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(NUM_CH)-1:0]  ch_out,
    output logic [NUM_CH-1:0]          overrun_out,
    input  logic                       clear_overrun_in
`ifdef MIC_ARB_TIMESTAMP_EN
    ,
    input  logic                       tick_in,
    output logic [TS_W-1:0]            ts_out
`endif
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W:0]   NUM_CH_W = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] RR_RST   = CH_W'(NUM_CH - 1);

    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   overrun_q, overrun_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   slot_data_q [NUM_CH];
    logic [DATA_W-1:0]   slot_data_d [NUM_CH];

    logic                load;
    logic                grant_vld;
    logic [CH_W-1:0]     grant_ch;
    logic [CH_W:0]       scan_sum;
    logic [CH_W-1:0]     scan_idx;
    logic [NUM_CH-1:0]   granted;

`ifdef MIC_ARB_TIMESTAMP_EN
    logic [TS_W-1:0]     ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [TS_W-1:0]     slot_ts_q [NUM_CH];
    logic [TS_W-1:0]     slot_ts_d [NUM_CH];
`endif

    assign load = !valid_q || ready_in;

    // Scan from the farthest offset down so the nearest pending channel after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (load) begin
            for (int off = NUM_CH; off >= 1; off--) begin
                scan_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(off);
                if (scan_sum >= NUM_CH_W) begin
                    scan_sum = scan_sum - NUM_CH_W;
                end
                scan_idx = scan_sum[CH_W-1:0];
                if (pending_q[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_ch  = scan_idx;
                end
            end
        end
    end

    always_comb begin
        granted   = '0;
        pending_d = pending_q;
        overrun_d = clear_overrun_in ? '0 : overrun_q;
        for (int i = 0; i < NUM_CH; i++) begin
            slot_data_d[i] = slot_data_q[i];
            granted[i]     = grant_vld && (grant_ch == CH_W'(i));
            if (granted[i]) begin
                pending_d[i] = 1'b0;
            end
            // A fresh strobe always refills the slot; it only counts as an overrun if the old sample is lost.
            if (valid_in[i]) begin
                slot_data_d[i] = data_in[i*DATA_W +: DATA_W];
                pending_d[i]   = 1'b1;
                if (pending_q[i] && !granted[i]) begin
                    overrun_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        ch_d     = ch_q;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            valid_d = grant_vld;
            if (grant_vld) begin
                data_d   = slot_data_q[grant_ch];
                ch_d     = grant_ch;
                rr_ptr_d = grant_ch;
            end
        end
    end

`ifdef MIC_ARB_TIMESTAMP_EN
    always_comb begin
        ts_cnt_d = tick_in ? ts_cnt_q + 1'b1 : ts_cnt_q;
        ts_d     = ts_q;
        if (load && grant_vld) begin
            ts_d = slot_ts_q[grant_ch];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            slot_ts_d[i] = valid_in[i] ? ts_cnt_q : slot_ts_q[i];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
        end
    end

    always_ff @(posedge clk_in) begin
        slot_ts_q <= slot_ts_d;
    end

    assign ts_out = ts_q;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            ch_q      <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            rr_ptr_q  <= RR_RST;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            ch_q      <= ch_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Slot contents are qualified by pending_q, so they need no reset.
    always_ff @(posedge clk_in) begin
        slot_data_q <= slot_data_d;
    end

    assign valid_out   = valid_q;
    assign data_out    = data_q;
    assign ch_out      = ch_q;
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_mic_sample_arbiter.sv
// Scoreboard bench for mic_sample_arbiter: expected (channel, sample) pairs queued at stimulus time,
// popped and compared on every output handshake.
module tb_mic_sample_arbiter;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 16;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic [NUM_CH-1:0]         valid_in;
    logic [NUM_CH*DATA_W-1:0]  data_in;
    logic                      ready_in;
    logic                      valid_out;
    logic [DATA_W-1:0]         data_out;
    logic [1:0]                ch_out;
    logic [NUM_CH-1:0]         overrun_out;
    logic                      clear_overrun_in;
`ifdef MIC_ARB_TIMESTAMP_EN
    logic                      tick_in;
    logic [15:0]               ts_out;
`endif

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   hs_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [1:0]  prev_ch;

    mic_sample_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .valid_in         (valid_in),
        .data_in          (data_in),
        .ready_in         (ready_in),
        .valid_out        (valid_out),
        .data_out         (data_out),
        .ch_out           (ch_out),
        .overrun_out      (overrun_out),
        .clear_overrun_in (clear_overrun_in)
`ifdef MIC_ARB_TIMESTAMP_EN
        ,
        .tick_in          (tick_in),
        .ts_out           (ts_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Scoreboard monitor: mid-cycle sampling, inputs are stable between edges.
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (valid_out) begin
                chk_cnt++;
                if (ch_out >= 2'(NUM_CH)) $display("FAIL ch_range: ch_out=%0d required < %0d", ch_out, NUM_CH);
                else pass_cnt++;
            end
            if (prev_stall) begin
                chk_cnt++;
                if (!valid_out || data_out !== prev_data || ch_out !== prev_ch)
                    $display("FAIL stall_hold: valid=%b data=%h ch=%0d required valid=1 data=%h ch=%0d",
                             valid_out, data_out, ch_out, prev_data, prev_ch);
                else pass_cnt++;
            end
            if (valid_out && ready_in) begin
                hs_cnt++;
                chk_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_out: ch=%0d data=%h required no output", ch_out, data_out);
                end else begin
                    mon_e = sb.pop_front();
                    if (ch_out !== mon_e.ch || data_out !== mon_e.data)
                        $display("FAIL sb_out: ch=%0d data=%h required ch=%0d data=%h",
                                 ch_out, data_out, mon_e.ch, mon_e.data);
                    else pass_cnt++;
                end
            end
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
            prev_ch    = ch_out;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] v);
        data_in[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        #1;
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step();
        step();
        chk_cnt++; if (valid_out !== 1'b0) $display("FAIL rst_valid: got %b required 0", valid_out); else pass_cnt++;
        chk_cnt++; if (data_out !== 16'h0) $display("FAIL rst_data: got %h required 0000", data_out); else pass_cnt++;
        chk_cnt++; if (ch_out !== 2'd0) $display("FAIL rst_ch: got %0d required 0", ch_out); else pass_cnt++;
        chk_cnt++; if (overrun_out !== 3'b000) $display("FAIL rst_overrun: got %b required 000", overrun_out); else pass_cnt++;
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_single();
        ready_in = 1'b1;
        valid_in = 3'b001;
        set_ch(0, 16'h1234);
        sb.push_back('{ch: 2'd0, data: 16'h1234});
        step();
        valid_in = 3'b000;
        chk_cnt++; if (valid_out !== 1'b0) $display("FAIL lat_early: valid=%b required 0", valid_out); else pass_cnt++;
        step();
        chk_cnt++;
        if (valid_out !== 1'b1 || ch_out !== 2'd0 || data_out !== 16'h1234)
            $display("FAIL lat_out: valid=%b ch=%0d data=%h required 1/0/1234", valid_out, ch_out, data_out);
        else pass_cnt++;
        step();
        chk_cnt++; if (valid_out !== 1'b0) $display("FAIL single_idle: valid=%b required 0", valid_out); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready_in = 1'b1;
        valid_in = 3'b111;
        set_ch(0, 16'hA000); set_ch(1, 16'hB001); set_ch(2, 16'hC002);
        sb.push_back('{ch: 2'd0, data: 16'hA000});
        sb.push_back('{ch: 2'd1, data: 16'hB001});
        sb.push_back('{ch: 2'd2, data: 16'hC002});
        step();
        valid_in = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++;
            if (valid_out !== 1'b1 || ch_out !== 2'(i))
                $display("FAIL b2b_seq%0d: valid=%b ch=%0d required 1/%0d", i, valid_out, ch_out, i);
            else pass_cnt++;
        end
        step();
        chk_cnt++; if (valid_out !== 1'b0) $display("FAIL b2b_idle: valid=%b required 0", valid_out); else pass_cnt++;
        chk_cnt++; if (overrun_out !== 3'b000) $display("FAIL b2b_overrun: got %b required 000", overrun_out); else pass_cnt++;
    endtask

    task automatic test_overrun();
        do_reset();
        ready_in = 1'b0;
        valid_in = 3'b001;
        set_ch(0, 16'h00C0);
        sb.push_back('{ch: 2'd0, data: 16'h00C0});
        step();
        valid_in = 3'b010;
        set_ch(1, 16'h0011);
        step();
        set_ch(1, 16'h0022);
        sb.push_back('{ch: 2'd1, data: 16'h0022});
        step();
        valid_in = 3'b000;
        chk_cnt++; if (overrun_out !== 3'b010) $display("FAIL ovr_flag: got %b required 010", overrun_out); else pass_cnt++;
        chk_cnt++;
        if (valid_out !== 1'b1 || data_out !== 16'h00C0 || ch_out !== 2'd0)
            $display("FAIL ovr_held: valid=%b ch=%0d data=%h required 1/0/00c0", valid_out, ch_out, data_out);
        else pass_cnt++;
        ready_in = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step();
        chk_cnt++; if (sb.size() != 0) $display("FAIL ovr_drain: %0d left required 0", sb.size()); else pass_cnt++;
        chk_cnt++; if (overrun_out !== 3'b010) $display("FAIL ovr_sticky: got %b required 010", overrun_out); else pass_cnt++;
    endtask

    task automatic test_clear_overrun();
        ready_in = 1'b0;
        valid_in = 3'b001;
        set_ch(0, 16'h4000);
        sb.push_back('{ch: 2'd0, data: 16'h4000});
        step();
        valid_in = 3'b100;
        set_ch(2, 16'h4201);
        step();
        set_ch(2, 16'h4202);
        clear_overrun_in = 1'b1;
        sb.push_back('{ch: 2'd2, data: 16'h4202});
        step();
        valid_in = 3'b000;
        clear_overrun_in = 1'b0;
        chk_cnt++; if (overrun_out !== 3'b100) $display("FAIL clr_setwins: got %b required 100", overrun_out); else pass_cnt++;
        ready_in = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step();
        chk_cnt++; if (sb.size() != 0) $display("FAIL clr_drain: %0d left required 0", sb.size()); else pass_cnt++;
        clear_overrun_in = 1'b1;
        step();
        clear_overrun_in = 1'b0;
        chk_cnt++; if (overrun_out !== 3'b000) $display("FAIL clr_only: got %b required 000", overrun_out); else pass_cnt++;
    endtask

    task automatic test_fairness();
        int hs_start;
        do_reset();
        for (int i = 0; i < 60; i++) sb.push_back('{ch: 2'(i % 3), data: 16'h5A00 + 16'(i % 3)});
        hs_start = hs_cnt;
        ready_in = 1'b1;
        valid_in = 3'b111;
        set_ch(0, 16'h5A00); set_ch(1, 16'h5A01); set_ch(2, 16'h5A02);
        for (int i = 0; i < 20; i++) begin
            step();
            ready_in = ~ready_in;
        end
        valid_in = 3'b000;
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk_cnt++; if (hs_cnt - hs_start < 8) $display("FAIL rr_count: got %0d required >= 8", hs_cnt - hs_start); else pass_cnt++;
        chk_cnt++; if (valid_out !== 1'b0) $display("FAIL rr_idle: valid=%b required 0", valid_out); else pass_cnt++;
        chk_cnt++; if (overrun_out !== 3'b111) $display("FAIL rr_overrun: got %b required 111", overrun_out); else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_reset_midstream();
        int stale;
        do_reset();
        ready_in = 1'b0;
        valid_in = 3'b111;
        set_ch(0, 16'h6000); set_ch(1, 16'h6001); set_ch(2, 16'h6002);
        for (int i = 0; i < 3; i++) step();
        valid_in = 3'b000;
        #2;
        rst_in = 1'b1;
        #1;
        chk_cnt++;
        if (valid_out !== 1'b0 || data_out !== 16'h0 || ch_out !== 2'd0 || overrun_out !== 3'b000)
            $display("FAIL mid_rst: valid=%b data=%h ch=%0d ovr=%b required all 0", valid_out, data_out, ch_out, overrun_out);
        else pass_cnt++;
        sb.delete();
        step();
        rst_in = 1'b0;
        ready_in = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid_out) stale++;
        end
        chk_cnt++; if (stale != 0) $display("FAIL mid_stale: %0d valid cycles required 0", stale); else pass_cnt++;
    endtask

`ifdef MIC_ARB_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        ready_in = 1'b1;
        tick_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tick_in = 1'b0;
        valid_in = 3'b001;
        set_ch(0, 16'h7777);
        sb.push_back('{ch: 2'd0, data: 16'h7777});
        step();
        valid_in = 3'b000;
        step();
        chk_cnt++;
        if (valid_out !== 1'b1 || ts_out !== 16'd5)
            $display("FAIL ts_val: valid=%b ts=%0d required 1/5", valid_out, ts_out);
        else pass_cnt++;
        step();
    endtask
`endif

    initial begin
        rst_in = 1'b1;
        valid_in = '0;
        data_in = '0;
        ready_in = 1'b0;
        clear_overrun_in = 1'b0;
`ifdef MIC_ARB_TIMESTAMP_EN
        tick_in = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_clear_overrun();
        test_fairness();
        test_reset_midstream();
`ifdef MIC_ARB_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
